// File: rtl/sc_spi_target_pkg.sv
// Shared types and helpers for the sc_spi_target SPI target engine.
package sc_spi_target_pkg;

  localparam int PKG_MAX_DWIDTH = 32;
  localparam int POS_W          = $clog2(PKG_MAX_DWIDTH);
  localparam int IDX_W          = POS_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bit k of the transfer lives at shifter bit DWIDTH-1-k (MSB first) or k (LSB first).
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx,
                                               input logic             border,
                                               input logic [IDX_W-1:0] dwidth);
    return border ? idx : (dwidth - IDX_W'(1) - idx);
  endfunction

endpackage

// File: rtl/sc_spi_target_sync.sv
// Input synchronizers for CSB/SCLK/MOSI plus a registered SCLK edge detector
// (pin-to-edge-event latency SYNC_STAGES+1).
module sc_spi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic SYSCLK,
  input  logic SYSRSTB,
  input  logic CSB,
  input  logic SCLK,
  input  logic MOSI,
  output logic CSB_S,
  output logic MOSI_S,
  output logic SCLK_RISE,
  output logic SCLK_FALL
);

  logic [SYNC_STAGES-1:0] csb_ff;
  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   sclk_d;

  always_ff @(posedge SYSCLK) begin
    if (!SYSRSTB) begin
      csb_ff    <= '1;
      sclk_ff   <= '0;
      mosi_ff   <= '0;
      sclk_d    <= 1'b0;
      SCLK_RISE <= 1'b0;
      SCLK_FALL <= 1'b0;
    end else begin
      csb_ff    <= {csb_ff[SYNC_STAGES-2:0], CSB};
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], SCLK};
      mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_ff[SYNC_STAGES-1];
      SCLK_RISE <= sclk_ff[SYNC_STAGES-1] & ~sclk_d;
      SCLK_FALL <= ~sclk_ff[SYNC_STAGES-1] & sclk_d;
    end
  end

  assign CSB_S  = csb_ff[SYNC_STAGES-1];
  assign MOSI_S = mosi_ff[SYNC_STAGES-1];

endmodule

// File: rtl/sc_spi_target.sv
// SPI target engine: oversampled CSB/SCLK/MOSI, all CPOL/CPHA modes, one-word TX holding buffer.
// Define SC_SPI_TARGET_WCNT_EN to add the WCOUNT words-per-transaction output.
module sc_spi_target
  import sc_spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_DWIDTH  = PKG_MAX_DWIDTH
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRSTB,
  input  logic                  ENABLE,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  BORDER,
  input  logic [IDX_W-1:0]      DWIDTH,
  input  logic [MAX_DWIDTH-1:0] TXDATA,
  input  logic                  TXVALID,
  output logic                  TXREADY,
  output logic [MAX_DWIDTH-1:0] RXDATA,
  output logic                  RXVALID,
  output logic                  UNDERRUN,
  output logic                  BUSY,
  input  logic                  CSB,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE
`ifdef SC_SPI_TARGET_WCNT_EN
  ,
  output logic [7:0]            WCOUNT
`endif
);

  localparam logic [IDX_W-1:0] DW_MAX = IDX_W'(MAX_DWIDTH);

  state_t                 state, state_next;
  logic                   csb_s, mosi_s, sclk_rise, sclk_fall, csb_q;
  logic                   start, stop, active_run;
  logic                   cpol_q, cpha_q, border_q;
  logic [IDX_W-1:0]       dw_q, dw_in, idx, pos, start_pos;
  logic [MAX_DWIDTH-1:0]  hold_buf, tx_shift, rx_shift, rx_next, load_word;
  logic                   hold_full, accept, load;
  logic                   leading, trailing, sample, drive, word_done;

  sc_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .SYSCLK    (SYSCLK),
    .SYSRSTB   (SYSRSTB),
    .CSB       (CSB),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .CSB_S     (csb_s),
    .MOSI_S    (mosi_s),
    .SCLK_RISE (sclk_rise),
    .SCLK_FALL (sclk_fall)
  );

  always_ff @(posedge SYSCLK) begin
    if (!SYSRSTB) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: if (ENABLE && csb_q && !csb_s) begin
        state_next = ACTIVE;
        start      = 1'b1;
      end
      ACTIVE: if (!ENABLE || csb_s) begin
        state_next = IDLE;
        stop       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // DWIDTH of 0 (or anything beyond the shifter) means a full-width word.
  assign dw_in      = (DWIDTH == '0 || DWIDTH > DW_MAX) ? DW_MAX : DWIDTH;
  assign start_pos  = bit_pos('0, BORDER, dw_in);
  assign active_run = (state == ACTIVE) && !stop;
  assign leading    = cpol_q ? sclk_fall : sclk_rise;
  assign trailing   = cpol_q ? sclk_rise : sclk_fall;
  assign sample     = active_run && (cpha_q ? trailing : leading);
  assign drive      = active_run && (cpha_q ? leading : trailing);
  assign word_done  = sample && (idx == dw_q - IDX_W'(1));
  assign load       = start || word_done;
  assign load_word  = hold_full ? hold_buf : '0;
  assign accept     = TXVALID && !hold_full;
  assign TXREADY    = !hold_full;
  assign BUSY       = (state == ACTIVE);

  always_comb begin
    pos     = bit_pos(idx, border_q, dw_q);
    rx_next = rx_shift;
    rx_next[pos[POS_W-1:0]] = mosi_s;
  end

  always_ff @(posedge SYSCLK) begin
    if (!SYSRSTB) begin
      csb_q     <= 1'b1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      border_q  <= 1'b0;
      dw_q      <= DW_MAX;
      idx       <= '0;
      hold_buf  <= '0;
      hold_full <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      RXDATA    <= '0;
      RXVALID   <= 1'b0;
      UNDERRUN  <= 1'b0;
      MISO      <= 1'b0;
      MISO_OE   <= 1'b0;
    end else begin
      csb_q    <= csb_s;
      RXVALID  <= 1'b0;
      UNDERRUN <= 1'b0;
      // A load in the same cycle as an accept takes the old contents.
      if (accept) begin
        hold_buf  <= TXDATA;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        tx_shift <= load_word;
        UNDERRUN <= !hold_full;
      end
      if (start) begin
        cpol_q   <= CPOL;
        cpha_q   <= CPHA;
        border_q <= BORDER;
        dw_q     <= dw_in;
        idx      <= '0;
        rx_shift <= '0;
        MISO_OE  <= 1'b1;
        if (!CPHA) MISO <= load_word[start_pos[POS_W-1:0]];
      end
      if (stop) begin
        idx     <= '0;
        MISO_OE <= 1'b0;
      end
      if (drive) MISO <= tx_shift[pos[POS_W-1:0]];
      if (sample) begin
        if (word_done) begin
          idx      <= '0;
          rx_shift <= '0;
          RXDATA   <= rx_next;
          RXVALID  <= 1'b1;
        end else begin
          idx      <= idx + IDX_W'(1);
          rx_shift <= rx_next;
        end
      end
    end
  end

`ifdef SC_SPI_TARGET_WCNT_EN
  logic [7:0] wcount_q;

  always_ff @(posedge SYSCLK) begin
    if (!SYSRSTB)                            wcount_q <= '0;
    else if (start)                          wcount_q <= '0;
    else if (word_done && wcount_q != 8'hFF) wcount_q <= wcount_q + 8'd1;
  end

  assign WCOUNT = wcount_q;
`endif

endmodule

// File: doc/sc_spi_target.md
Name: sc_spi_target

Overview:
SPI target (slave) engine; the responder end of the SPI link driven by the team's SPI Lite initiator.
- Oversamples external CSB/SCLK/MOSI in the system clock domain and shifts words of programmable width in all four CPOL/CPHA modes.
- Drives MISO from a one-word TX holding buffer.
- Delivers received words to the register layer as one-cycle pulses.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (≥2)
MAX_DWIDTH, 32, maximum word width in bits

Ports:
SYSCLK  in  1  system clock
SYSRSTB  in  1  synchronous active-low reset
ENABLE  in  1  block enable; low = ignore bus, abort transfer
CPOL  in  1  SCLK idle level
CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge
BORDER  in  1  0 = MSB first, 1 = LSB first
DWIDTH  in  6  word width 1..32; 0 treated as 32
TXDATA  in  32  next word to send, LSB-justified
TXVALID  in  1  TXDATA valid
TXREADY  out  1  holding buffer empty; accept on TXVALID&TXREADY
RXDATA  out  32  last received word, LSB-justified, upper bits zero
RXVALID  out  1  one-cycle pulse, RXDATA updated
UNDERRUN  out  1  one-cycle pulse, word started with empty buffer
BUSY  out  1  transfer active (synchronized CSB low and ENABLE)
CSB  in  1  chip select, active low, asynchronous
SCLK  in  1  SPI clock, asynchronous
MOSI  in  1  SPI data in, asynchronous
MISO  out  1  SPI data out
MISO_OE  out  1  MISO output enable

Behaviour:
- All state is reset synchronously when SYSRSTB=0.
- Reset values: TXREADY=1, RXDATA=0, RXVALID=0, UNDERRUN=0, BUSY=0, MISO=0, MISO_OE=0; holding buffer empty; state IDLE.
- Synchronization: CSB, SCLK and MOSI each pass through a SYNC_STAGES synchronizer.
- Edge detection: one extra registered stage; latency is SYNC_STAGES+1 cycles from pin to edge event.
- SCLK timing requirement: high and low phases each ≥ SYNC_STAGES+2 SYSCLK cycles. Behaviour is undefined otherwise.
- Edge classes:
  - Leading edge = SCLK leaving CPOL level; trailing edge = return to CPOL level.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Drive edge = trailing if CPHA=0, leading if CPHA=1.
- CPOL, CPHA, BORDER and DWIDTH are latched on entry to ACTIVE and held until return to IDLE.
- State machine, states IDLE and ACTIVE:
  - IDLE→ACTIVE: synchronized CSB falls while ENABLE=1.
    - Bit index is cleared; the shifter loads the holding buffer.
    - If the buffer is empty, the shifter loads zeros and UNDERRUN pulses.
    - MISO_OE=1. If CPHA=0, MISO is driven with bit 0 of the word on the same cycle.
  - ACTIVE→IDLE: synchronized CSB rises, or ENABLE=0.
    - MISO_OE=0 next cycle.
    - A partial word is discarded: no RXVALID, the TX word in the shifter is lost, bit index is cleared.
- Drive edge: MISO <= shifter bit at the current index, where index k maps to bit DWIDTH-1-k if BORDER=0 and bit k if BORDER=1. For CPHA=0 the drive edge after the last sample drives bit 0 of the next word.
- Sample edge: MOSI is shifted into the RX shifter at the mapped position and the index increments.
- Word completion (index reaches DWIDTH on a sample edge):
  - RXDATA updates and RXVALID pulses on the following cycle.
  - Index returns to 0.
  - The shifter reloads from the holding buffer, or zeros with an UNDERRUN pulse if empty.
- Holding buffer: filled by TXVALID&TXREADY; emptied on each shifter load.
  - If a load and an accept occur in the same cycle, the load takes the old contents and the new word is stored, so TXREADY stays 0.
  - TXDATA bits at DWIDTH and above are ignored.
- RXVALID has no backpressure; the consumer must take RXDATA within one word time.
- Reset asserted mid-transfer aborts immediately; the bus is released (MISO_OE=0).

Optional Feature:
SC_SPI_TARGET_WCNT_EN
- Defined: adds output WCOUNT[7:0], the number of words completed in the current or last transaction. Cleared on IDLE→ACTIVE, increments on each RXVALID, saturates at 255, holds after CSB release, resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sc_spi_target_pkg holds:
  - state enum (IDLE, ACTIVE);
  - localparam for the bit-index width, $clog2(MAX_DWIDTH)+1;
  - function mapping bit index to shifter position from BORDER and DWIDTH.
- Sub-module sc_spi_target_sync holds the parameterized synchronizer plus the SCLK edge detector, outputting CSB_S, MOSI_S, SCLK_RISE and SCLK_FALL.

Test Plan:
- CPOL=0, CPHA=0, BORDER=0, DWIDTH=8, TXDATA=0xA5 preloaded, initiator sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; RXDATA=0x0000003C with one RXVALID pulse.
- CPOL=1, CPHA=1, BORDER=1, DWIDTH=16, TXDATA=0x1234, MOSI=0xBEEF → MISO LSB first returns 0x1234 at the initiator; RXDATA=0x0000BEEF.
- DWIDTH=0 (meaning 32), two back-to-back words with CSB held low, second TXDATA written after first load → two RXVALID pulses; second word sent correctly; no UNDERRUN.
- CSB falls with the buffer empty → UNDERRUN pulse; MISO all zeros for 8 bits; RXDATA still captured.
- CSB rises after 5 of 8 bits → no RXVALID; MISO_OE=0 within SYNC_STAGES+2 cycles; the next transaction starts at bit 0.
- SYSRSTB=0 mid-word → all outputs at reset values next cycle; with SC_SPI_TARGET_WCNT_EN, three words then CSB high → WCOUNT=3.
